queue_wrapper: RTL and testbench
================================

Name: queue_wrapper

Overview:
- Synchronous FIFO queue with valid/ready handshakes on both the enqueue and dequeue sides; default is 2 entries of 4 bits.
- Acts as a small elastic buffer between a producer and a consumer in the same clock domain.
- Read data is presented combinationally from storage; there is no enqueue-to-dequeue bypass.

Parameters:
- DATA_WIDTH, 4, width of each entry.
- DEPTH, 2, number of entries; must be a power of two and at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  enqueue data.
- enq_val  input  1  producer has valid data on din.
- enq_rdy  output  1  queue can accept an entry (not full).
- dout  output  DATA_WIDTH  data at the head of the queue.
- deq_val  output  1  queue holds at least one entry (not empty).
- deq_rdy  input  1  consumer accepts the head entry.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Storage: DEPTH x DATA_WIDTH register array.
- Pointers: read and write pointers, each log2(DEPTH)+1 bits. The extra MSB is the wrap bit.
  - Empty: pointers are equal.
  - Full: index bits are equal and wrap bits differ.
- Reset (asynchronous, any time, including mid-operation):
  - Both pointers and all storage entries clear to 0.
  - Afterwards: deq_val=0, enq_rdy=1, dout=0.
  - Reset dominates any handshake in the same cycle.
- Enqueue fire = enq_val & enq_rdy.
  - On the rising edge, din is written to mem[wr_idx] and the write pointer increments, wrapping modulo 2*DEPTH.
  - enq_val while full is ignored: no write, no pointer change.
- Dequeue fire = deq_val & deq_rdy.
  - On the rising edge, the read pointer increments.
  - deq_rdy while empty is ignored.
  - Storage is not cleared on dequeue.
- Outputs are purely combinational from state; no dependence on enq_val or deq_rdy in the same cycle.
  - enq_rdy = !full.
  - deq_val = !empty.
  - dout = mem[rd_idx] at all times.
- Stale data: when empty, dout still shows the stale entry at the read index. Consumers must qualify dout with deq_val.
- Latency: an entry enqueued on edge N is visible on dout/deq_val after edge N (one-cycle latency); no same-cycle bypass.
- Simultaneous enqueue and dequeue fire (queue neither empty nor full): both occur, occupancy unchanged, FIFO order preserved.
- Full with deq_rdy=1: enq_rdy stays 0 that cycle (no pass-through); space appears the cycle after the dequeue.
- Ordering: strict FIFO. Pointer wrap-around is seamless across any number of cycles.

Test Plan:
- Reset then idle:
  - During and after reset -> deq_val=0, enq_rdy=1, dout=0.
- Fill to full (din=1 with enq_val=1 for one edge, then din=2 for one edge, then enq_val=0):
  - After the first edge -> deq_val=1, enq_rdy=1, dout=1.
  - After the second edge -> deq_val=1, enq_rdy=0, dout=1.
  - With enq_val=0 and deq_rdy=0, held across an extra edge -> state unchanged.
- Drain (deq_rdy=1 for two edges from the full state):
  - After the first edge -> dout=2, deq_val=1, enq_rdy=1.
  - After the second edge -> deq_val=0, enq_rdy=1, dout=1 (stale slot 0 after wrap).
- Full-queue guards:
  - Enqueue din=3 while full -> ignored; the later drain returns 1, 2 only.
  - Dequeue while empty -> no pointer change; the next enqueue of 5 yields dout=5.
- Concurrent and wrap:
  - With one entry held, enqueue and dequeue fire on the same edge, repeated over 10 edges with incrementing data -> deq_val stays 1, enq_rdy stays 1, dout sequence matches input order through multiple pointer wraps.
- Mid-operation reset:
  - Assert reset asynchronously (between edges) while the queue is full -> immediately deq_val=0, enq_rdy=1, dout=0.

Source files
------------

// File: rtl/queue_wrapper_if.sv
// ---------------------------------------------------------------------------
// queue_wrapper_if
//   Handshake bundle for queue_wrapper: the enqueue side (din/enq_val/enq_rdy)
//   and the dequeue side (dout/deq_val/deq_rdy).
//   Modports:
//     master - environment side: drives din, enq_val, deq_rdy;
//              observes enq_rdy, dout, deq_val.
//     slave  - queue side: the mirror image of master.
// ---------------------------------------------------------------------------
interface queue_wrapper_if #(
    parameter int DATA_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] din;
    logic                  enq_val;
    logic                  enq_rdy;
    logic [DATA_WIDTH-1:0] dout;
    logic                  deq_val;
    logic                  deq_rdy;

    modport master (
        output din, enq_val, deq_rdy,
        input  enq_rdy, dout, deq_val
    );

    modport slave (
        input  din, enq_val, deq_rdy,
        output enq_rdy, dout, deq_val
    );
endinterface

// File: rtl/queue_wrapper.sv
// ---------------------------------------------------------------------------
// queue_wrapper
//   Synchronous FIFO acting as an elastic buffer between a producer and a
//   consumer in one clock domain. Storage is a DEPTH x DATA_WIDTH register
//   array addressed by read/write pointers that carry an extra wrap bit.
//   The head entry is shown combinationally on dout; there is no
//   enqueue-to-dequeue bypass.
//   Ports:
//     clk   - single clock, rising edge
//     reset - asynchronous, active-high; clears pointers and storage
//     q     - queue_wrapper_if.slave handshake bundle
//               din/enq_val/enq_rdy : enqueue side (enq_rdy = not full)
//               dout/deq_val/deq_rdy: dequeue side (deq_val = not empty)
//   dout always shows mem[rd_idx]; when empty it is a stale entry and must
//   be qualified with deq_val.
// ---------------------------------------------------------------------------
module queue_wrapper #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 2    // power of two, at least 2
) (
    input  logic              clk,
    input  logic              reset,
    queue_wrapper_if.slave    q
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;

    logic full;
    logic empty;
    logic enq_fire;
    logic deq_fire;

    // Equal pointers mean empty; equal index with opposite wrap bits means
    // the writer is a whole lap ahead, i.e. full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Ready/valid depend on state only, so a full queue does not accept a
    // new entry in the same cycle it is being drained.
    assign q.enq_rdy = !full;
    assign q.deq_val = !empty;
    assign q.dout    = mem[rd_ptr[AW-1:0]];

    assign enq_fire = q.enq_val && !full;
    assign deq_fire = q.deq_rdy && !empty;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + PTR_ONE;
            if (deq_fire) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is reset on purpose so that dout reads 0 after reset even
    // though deq_val is low; this makes the array real flops, not a RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (enq_fire) begin
            mem[wr_ptr[AW-1:0]] <= q.din;
        end
    end
endmodule

// File: tb/tb_queue_wrapper.sv
// ---------------------------------------------------------------------------
// tb_queue_wrapper
//   Scoreboard bench for queue_wrapper (DATA_WIDTH=4, DEPTH=2).
//   The driver changes inputs 1 ns after each rising edge and pushes every
//   accepted entry into exp_q. The monitor samples on the falling edge,
//   checks status flags and dout against a reference model built from
//   enqueue/dequeue counts and the history of accepted data, and pops exp_q
//   on every dequeue handshake.
// ---------------------------------------------------------------------------
module tb_queue_wrapper;
    localparam int DW    = 4;
    localparam int DEPTH = 2;

    logic clk;
    logic reset;

    queue_wrapper_if #(.DATA_WIDTH(DW)) q ();

    queue_wrapper #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DW-1:0] exp_q [$];   // scoreboard: accepted entries in order
    logic [DW-1:0] hist  [$];   // reference model: every entry accepted since reset
    int            enq_cnt;
    int            deq_cnt;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // One stimulus step: inputs take effect at the next rising edge.
    task automatic step(input logic ev, input logic [DW-1:0] d, input logic dr);
        @(posedge clk);
        #1;
        q.enq_val = ev;
        q.din     = d;
        q.deq_rdy = dr;
        if (!reset && ev && q.enq_rdy) exp_q.push_back(d);
    endtask

    // Monitor / reference model
    initial begin
        int            occ;
        logic          m_enq;
        logic          m_deq;
        logic [DW-1:0] exp_dout;
        logic [DW-1:0] sb;
        enq_cnt = 0;
        deq_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_deq_val", int'(q.deq_val), 0);
                check("rst_enq_rdy", int'(q.enq_rdy), 1);
                check("rst_dout",    int'(q.dout),    0);
                hist.delete();
                enq_cnt = 0;
                deq_cnt = 0;
            end else begin
                occ = enq_cnt - deq_cnt;
                check("deq_val", int'(q.deq_val), (occ > 0) ? 1 : 0);
                check("enq_rdy", int'(q.enq_rdy), (occ < DEPTH) ? 1 : 0);
                if (occ > 0)
                    exp_dout = hist[deq_cnt];
                else if (deq_cnt >= DEPTH)
                    exp_dout = hist[deq_cnt - DEPTH];   // stale slot content
                else
                    exp_dout = '0;
                check("dout", int'(q.dout), int'(exp_dout));

                m_enq = q.enq_val && (occ < DEPTH);
                m_deq = q.deq_rdy && (occ > 0);
                if (m_deq) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        sb = exp_q.pop_front();
                        check("sb_dout", int'(q.dout), int'(sb));
                    end
                end
                if (m_enq) begin
                    hist.push_back(q.din);
                    enq_cnt++;
                end
                if (m_deq) deq_cnt++;
            end
        end
    end

    // Driver
    initial begin
        reset     = 1'b1;
        q.din     = '0;
        q.enq_val = 1'b0;
        q.deq_rdy = 1'b0;
        #1;
        check("por_deq_val", int'(q.deq_val), 0);
        check("por_enq_rdy", int'(q.enq_rdy), 1);
        check("por_dout",    int'(q.dout),    0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0, 4'd0, 1'b0);

        // Fill to full, try to enqueue while full, hold.
        step(1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        step(1'b1, 4'd3, 1'b0);   // full: ignored
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);

        // Drain, then dequeue attempt while empty.
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1);   // empty: ignored
        step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd5, 1'b0);
        step(1'b0, 4'd0, 1'b0);

        // Concurrent enqueue/dequeue with one entry held, across wraps.
        for (int i = 0; i < 10; i++) step(1'b1, 4'(6 + i), 1'b1);
        step(1'b0, 4'd0, 1'b0);

        // Fill, then reset asynchronously between edges.
        step(1'b1, 4'd9, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        @(posedge clk);
        #3;
        check("pre_rst_full", int'(q.enq_rdy), 0);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("async_deq_val", int'(q.deq_val), 0);
        check("async_enq_rdy", int'(q.enq_rdy), 1);
        check("async_dout",    int'(q.dout),    0);
        // Handshakes during reset must have no effect.
        q.enq_val = 1'b1;
        q.din     = 4'd7;
        q.deq_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        q.enq_val = 1'b0;
        q.deq_rdy = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));

        // Drain whatever is left.
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        check("sb_empty_at_end", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
